// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] ZERO = 3'd0;
  localparam logic [2:0] PM1  = 3'd1;
  localparam logic [2:0] PM2  = 3'd2;
  localparam logic [2:0] NM1  = 3'd3;
  localparam logic [2:0] NM2  = 3'd4;

  // Two guard bits keep +/-2M from overflowing the accumulator.
  function automatic int acc_width(input int width);
    return width + 2;
  endfunction

  function automatic logic [2:0] recode(input logic [2:0] trip);
    logic [2:0] digit;
    case (trip)
      3'b001, 3'b010: digit = PM1;
      3'b011:         digit = PM2;
      3'b100:         digit = NM2;
      3'b101, 3'b110: digit = NM1;
      default:        digit = ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/booth_r4_step.sv
// One combinational radix-4 Booth step: add the recoded multiple of M, then
// arithmetic-shift {A,Q,Q_minus_1} right by two.
module booth_r4_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int AW = acc_width(WIDTH)
) (
  input  logic [AW-1:0]    a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             qm1_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [AW-1:0]    a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             qm1_o
);

  logic [AW-1:0] m_ext;
  logic [AW-1:0] m_dbl;
  logic [AW-1:0] addend;
  logic [AW-1:0] sum;

  always_comb begin
    m_ext  = {{2{m_i[WIDTH-1]}}, m_i};
    m_dbl  = {m_ext[AW-2:0], 1'b0};
    addend = '0;
    case (recode({q_i[1:0], qm1_i}))
      PM1:     addend = m_ext;
      PM2:     addend = m_dbl;
      NM1:     addend = -m_ext;
      NM2:     addend = -m_dbl;
      default: addend = '0;
    endcase
    sum   = a_i + addend;
    // Sign of the post-add accumulator fills the two vacated top bits.
    a_o   = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_o   = {sum[1:0], q_i[WIDTH-1:2]};
    qm1_o = q_i[1];
  end

endmodule

// File: rtl/booth_radix4_seq_ctrl.sv
// Sequential signed radix-4 Booth multiplier controller: accepts an operand
// pair, runs WIDTH/2 steps, then holds the product until the consumer takes it.
//
//   state | meaning
//   IDLE  | ready for an operand pair
//   RUN   | one Booth step per clock
//   DONE  | product valid, waiting for out_ready
module booth_radix4_seq_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH/2 + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int AW = acc_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH/2 - 1);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_width_check
    $fatal(1, "booth_radix4_seq_ctrl: WIDTH must be even and >= 4");
  end

  state_e             state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [AW-1:0]      step_a;
  logic [WIDTH-1:0]   step_q;
  logic               step_qm1;

  booth_r4_step #(.WIDTH(WIDTH)) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .a_o   (step_a),
    .q_o   (step_q),
    .qm1_o (step_qm1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      qm1_q       <= 1'b0;
      m_q         <= '0;
      count_q     <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      qm1_q       <= qm1_d;
      m_q         <= m_d;
      count_q     <= count_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          qm1_d   = 1'b0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = step_a;
        q_d     = step_q;
        qm1_d   = step_qm1;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          product_d = {step_a[WIDTH-1:0], step_q};
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == RUN);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule

// File: tb/tb_booth_radix4_seq_ctrl.sv
// Directed and random checks of the Booth controller at WIDTH=4 and WIDTH=8,
// using product scoreboards and accept-to-valid latency measurement.
module tb_booth_radix4_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv4, ir4, ov4, or4, busy4;
  logic [3:0] mc4, mq4;
  logic [7:0] p4;

  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  mc8, mq8;
  logic [15:0] p8;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0]  sb4[$];
  logic [15:0] sb8[$];

  booth_radix4_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .multiplicand(mc4), .multiplier(mq4), .out_valid(ov4),
    .out_ready(or4), .product(p4), .busy(busy4)
  );

  booth_radix4_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .multiplicand(mc8), .multiplier(mq8), .out_valid(ov8),
    .out_ready(or8), .product(p8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is #1 after a posedge with dut4 idle; leaves dut4 idle again.
  task automatic do4(input logic signed [3:0] m, input logic signed [3:0] q, input string tag);
    int k;
    int e;
    logic [7:0] exp_p;
    k = 0;
    while (!ir4 && k < 20) begin tick(); k++; end
    mc4 = m; mq4 = q; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    e = int'(m) * int'(q);
    sb4.push_back(8'(e));
    mc4 = ~m; mq4 = ~q;
    check({tag, "_busy"}, {31'b0, busy4}, 32'd1);
    check({tag, "_inrdy_run"}, {31'b0, ir4}, 32'd0);
    k = 0;
    while (!ov4 && k < 20) begin tick(); k++; end
    check({tag, "_lat"}, k, 32'd2);
    exp_p = (sb4.size() > 0) ? sb4.pop_front() : 8'hxx;
    check({tag, "_prod"}, {24'b0, p4}, {24'b0, exp_p});
    tick();
  endtask

  task automatic do8(input logic signed [7:0] m, input logic signed [7:0] q);
    int k;
    int e;
    logic [15:0] exp_p;
    k = 0;
    while (!ir8 && k < 30) begin tick(); k++; end
    mc8 = m; mq8 = q; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    e = int'(m) * int'(q);
    sb8.push_back(16'(e));
    mc8 = 8'($urandom); mq8 = 8'($urandom);
    k = 0;
    while (!ov8 && k < 30) begin tick(); k++; end
    check("w8_lat", k, 32'd4);
    exp_p = (sb8.size() > 0) ? sb8.pop_front() : 16'hxxxx;
    check("w8_prod", {16'b0, p8}, {16'b0, exp_p});
    tick();
  endtask

  initial begin
    int k;
    int extra;
    logic [7:0] held;
    logic stable;

    rst = 1'b1;
    iv4 = 1'b0; mc4 = '0; mq4 = '0; or4 = 1'b1;
    iv8 = 1'b0; mc8 = '0; mq8 = '0; or8 = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_inrdy", {31'b0, ir4}, 32'd1);
    check("rst_ovalid", {31'b0, ov4}, 32'd0);
    check("rst_busy", {31'b0, busy4}, 32'd0);
    check("rst_prod", {24'b0, p4}, 32'd0);

    do4(4'sd3, -4'sd2, "3x-2");
    do4(-4'sd8, -4'sd8, "-8x-8");
    do4(4'sd7, -4'sd8, "7x-8");
    do4(4'sd7, 4'sd7, "7x7");
    check("after_idle_inrdy", {31'b0, ir4}, 32'd1);

    // Backpressure: product held, new operands ignored while DONE.
    or4 = 1'b0;
    mc4 = 4'sd5; mq4 = -4'sd3; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    sb4.push_back(8'hF1);
    k = 0;
    while (!ov4 && k < 20) begin tick(); k++; end
    check("bp_lat", k, 32'd2);
    held = p4;
    check("bp_prod", {24'b0, p4}, {24'b0, sb4.pop_front()});
    mc4 = 4'sd1; mq4 = 4'sd1; iv4 = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!ov4 || ir4 || p4 !== held) stable = 1'b0;
    end
    check("bp_stable", {31'b0, stable}, 32'd1);
    iv4 = 1'b0;
    or4 = 1'b1;
    tick();
    check("bp_release_ovalid", {31'b0, ov4}, 32'd0);
    check("bp_release_inrdy", {31'b0, ir4}, 32'd1);
    check("bp_prod_kept", {24'b0, p4}, 32'h000000F1);

    // Operands offered during RUN are ignored.
    mc4 = 4'sd3; mq4 = 4'sd3; iv4 = 1'b1;
    tick();
    sb4.push_back(8'h09);
    mc4 = 4'sd5; mq4 = 4'sd5;
    k = 0;
    while (!ov4 && k < 20) begin tick(); k++; end
    check("run_ign_lat", k, 32'd2);
    check("run_ign_prod", {24'b0, p4}, {24'b0, sb4.pop_front()});
    iv4 = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ov4) extra++;
    end
    check("run_ign_extra", extra, 32'd0);

    // Reset mid-RUN discards the partial result.
    mc4 = 4'sd6; mq4 = 4'sd7; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_inrdy", {31'b0, ir4}, 32'd1);
    check("midrst_ovalid", {31'b0, ov4}, 32'd0);
    check("midrst_busy", {31'b0, busy4}, 32'd0);
    check("midrst_prod", {24'b0, p4}, 32'd0);
    do4(4'sd2, 4'sd3, "2x3");

    // WIDTH=8 corners then random pairs.
    do8(-8'sd128, -8'sd128);
    do8(-8'sd128, 8'sd127);
    do8(8'sd127, 8'sd127);
    do8(8'sd0, -8'sd1);
    for (int i = 0; i < 1000; i++) begin
      do8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    check("sb8_empty", sb8.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
